// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection and the
// engine state types used by the internal-bus to AXI4-Lite master bridge.
package axi4l_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_ACK} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP, R_ACK} r_state_e;

   // EXOKAY is folded into success; only SLVERR/DECERR flag an error.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/int_axi4l.sv
// Internal register bus to AXI4-Lite master bridge with independent write and
// read engines, each holding at most one outstanding transaction.
//
// state  | meaning
// W_IDLE | waiting for int_wr_en
// W_REQ  | awvalid/wvalid up until each handshake completes
// W_RESP | bready up, waiting for bvalid
// W_ACK  | one-cycle int_wr_ack / int_wr_err
// R_IDLE | waiting for int_rd_en
// R_REQ  | arvalid up until the AR handshake
// R_RESP | rready up, waiting for rvalid
// R_ACK  | one-cycle int_rd_ack, int_rd_data updated
module int_axi4l
   import axi4l_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter int          DATA_WIDTH = 32,
   parameter logic [2:0]  PROT       = PROT_DEFAULT
) (
   input  logic                    m_axi_aclk,
   input  logic                    m_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   int_addr,
   input  logic [DATA_WIDTH-1:0]   int_wr_data,
   input  logic [DATA_WIDTH/8-1:0] int_wr_strb,
   input  logic                    int_wr_en,
   input  logic                    int_rd_en,
   output logic                    int_wr_ack,
   output logic                    int_wr_err,
   output logic                    int_rd_ack,
   output logic                    int_rd_err,
   output logic [DATA_WIDTH-1:0]   int_rd_data,
   output logic                    int_wr_busy,
   output logic                    int_rd_busy,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int STRB_W = DATA_WIDTH / 8;

   w_state_e                w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic                    wr_busy_q, wr_busy_d;

   r_state_e                r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic                    arvalid_q, arvalid_d, rready_q, rready_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                    rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
   logic                    rd_busy_q, rd_busy_d;

   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      wr_ack_d  = 1'b0;
      wr_err_d  = 1'b0;
      case (w_state_q)
         W_IDLE: if (int_wr_en) begin
            awaddr_d  = int_addr;
            wdata_d   = int_wr_data;
            wstrb_d   = int_wr_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            w_state_d = W_REQ;
         end
         W_REQ: begin
            // AW and W complete independently, in either order.
            if (m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d  = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (m_axi_bvalid) begin
            bready_d  = 1'b0;
            wr_ack_d  = 1'b1;
            wr_err_d  = resp_is_err(m_axi_bresp);
            w_state_d = W_ACK;
         end
         default: w_state_d = W_IDLE;
      endcase
      wr_busy_d = (w_state_d != W_IDLE);
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         w_state_q <= W_IDLE;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         wr_ack_q  <= 1'b0;
         wr_err_q  <= 1'b0;
         wr_busy_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         wr_ack_q  <= wr_ack_d;
         wr_err_q  <= wr_err_d;
         wr_busy_q <= wr_busy_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      rd_data_d = rd_data_q;
      rd_ack_d  = 1'b0;
      rd_err_d  = 1'b0;
      case (r_state_q)
         R_IDLE: if (int_rd_en) begin
            araddr_d  = int_addr;
            arvalid_d = 1'b1;
            r_state_d = R_REQ;
         end
         R_REQ: if (m_axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            r_state_d = R_RESP;
         end
         R_RESP: if (m_axi_rvalid) begin
            rready_d  = 1'b0;
            rd_data_d = m_axi_rdata;
            rd_ack_d  = 1'b1;
            rd_err_d  = resp_is_err(m_axi_rresp);
            r_state_d = R_ACK;
         end
         default: r_state_d = R_IDLE;
      endcase
      rd_busy_d = (r_state_d != R_IDLE);
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_state_q <= R_IDLE;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_busy_q <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
         rd_err_q  <= rd_err_d;
         rd_busy_q <= rd_busy_d;
      end
   end

   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = PROT;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = PROT;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;
   assign int_wr_ack    = wr_ack_q;
   assign int_wr_err    = wr_err_q;
   assign int_wr_busy   = wr_busy_q;
   assign int_rd_ack    = rd_ack_q;
   assign int_rd_err    = rd_err_q;
   assign int_rd_data   = rd_data_q;
   assign int_rd_busy   = rd_busy_q;

endmodule

// File: tb/tb_int_axi4l.sv
// Bench for int_axi4l: directed scenarios plus randomized traffic against a
// delay-configurable AXI4-Lite slave and a queue-based transaction model.
module tb_int_axi4l;
   import axi4l_pkg::*;

   logic        m_axi_aclk = 1'b0;
   logic        m_axi_aresetn = 1'b0;
   logic [9:0]  int_addr = '0;
   logic [31:0] int_wr_data = '0;
   logic [3:0]  int_wr_strb = '0;
   logic        int_wr_en = 1'b0, int_rd_en = 1'b0;
   logic        int_wr_ack, int_wr_err, int_rd_ack, int_rd_err;
   logic [31:0] int_rd_data;
   logic        int_wr_busy, int_rd_busy;
   logic [9:0]  m_axi_awaddr, m_axi_araddr;
   logic [2:0]  m_axi_awprot, m_axi_arprot;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
   logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
   logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
   logic [31:0] m_axi_rdata = '0;

   int_axi4l dut (
      .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
      .int_addr(int_addr), .int_wr_data(int_wr_data), .int_wr_strb(int_wr_strb),
      .int_wr_en(int_wr_en), .int_rd_en(int_rd_en),
      .int_wr_ack(int_wr_ack), .int_wr_err(int_wr_err),
      .int_rd_ack(int_rd_ack), .int_rd_err(int_rd_err), .int_rd_data(int_rd_data),
      .int_wr_busy(int_wr_busy), .int_rd_busy(int_rd_busy),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial forever #5 m_axi_aclk = ~m_axi_aclk;

   int tests = 0, fails = 0, viol = 0, cyc = 0;
   always @(posedge m_axi_aclk) cyc <= cyc + 1;

   // slave configuration
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   bit          rand_dly = 0;
   logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
   logic [31:0] rdata_cfg = '0;

   // observed traffic
   logic [12:0] aw_q[$], ar_q[$];
   logic [35:0] w_q[$];
   logic [1:0]  b_sent[$];
   logic [33:0] r_sent[$];
   logic        wack_err[$];
   int          wack_cyc[$], rack_cyc[$];
   logic [32:0] rack_q[$];

   function automatic int pick(input int fixed);
      if (rand_dly) return int'($urandom_range(0, 10));
      return fixed;
   endfunction

   function automatic logic exp_err(input logic [1:0] r);
      return (r == RESP_SLVERR) || (r == RESP_DECERR);
   endfunction

   int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   bit  aw_arm, w_arm, ar_arm, b_arm, r_arm;

   initial forever begin
      @(posedge m_axi_aclk); #1;
      if (!m_axi_aresetn) begin
         m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
         m_axi_bvalid = 0; m_axi_rvalid = 0;
         aw_arm = 0; w_arm = 0; ar_arm = 0; b_arm = 0; r_arm = 0;
      end else begin
         if (m_axi_awready) m_axi_awready = 0;
         else if (m_axi_awvalid) begin
            if (!aw_arm) begin aw_arm = 1; aw_cnt = pick(aw_dly); end
            if (aw_cnt == 0) begin m_axi_awready = 1; aw_arm = 0; end else aw_cnt--;
         end
         if (m_axi_wready) m_axi_wready = 0;
         else if (m_axi_wvalid) begin
            if (!w_arm) begin w_arm = 1; w_cnt = pick(w_dly); end
            if (w_cnt == 0) begin m_axi_wready = 1; w_arm = 0; end else w_cnt--;
         end
         if (m_axi_arready) m_axi_arready = 0;
         else if (m_axi_arvalid) begin
            if (!ar_arm) begin ar_arm = 1; ar_cnt = pick(ar_dly); end
            if (ar_cnt == 0) begin m_axi_arready = 1; ar_arm = 0; end else ar_cnt--;
         end
         // a response is raised only while ready is high, so it lasts one cycle
         if (m_axi_bvalid) m_axi_bvalid = 0;
         else if (m_axi_bready) begin
            if (!b_arm) begin b_arm = 1; b_cnt = pick(b_dly); end
            if (b_cnt == 0) begin
               m_axi_bvalid = 1; b_arm = 0;
               m_axi_bresp = rand_dly ? 2'($urandom_range(0, 3)) : bresp_cfg;
               b_sent.push_back(m_axi_bresp);
            end else b_cnt--;
         end
         if (m_axi_rvalid) m_axi_rvalid = 0;
         else if (m_axi_rready) begin
            if (!r_arm) begin r_arm = 1; r_cnt = pick(r_dly); end
            if (r_cnt == 0) begin
               m_axi_rvalid = 1; r_arm = 0;
               m_axi_rresp = rand_dly ? 2'($urandom_range(0, 3)) : rresp_cfg;
               m_axi_rdata = rand_dly ? $urandom : rdata_cfg;
               r_sent.push_back({m_axi_rresp, m_axi_rdata});
            end else r_cnt--;
         end
      end
   end

   logic        pend_aw, pend_w, pend_ar, hs_aw, hs_w, hs_ar;
   logic [12:0] aw_hold, ar_hold;
   logic [35:0] w_hold;

   initial forever begin
      @(negedge m_axi_aclk);
      if (!m_axi_aresetn) begin
         pend_aw = 0; pend_w = 0; pend_ar = 0; hs_aw = 0; hs_w = 0; hs_ar = 0;
      end else begin
         if (pend_aw && (!m_axi_awvalid || {m_axi_awprot, m_axi_awaddr} != aw_hold)) viol++;
         if (pend_w && (!m_axi_wvalid || {m_axi_wstrb, m_axi_wdata} != w_hold)) viol++;
         if (pend_ar && (!m_axi_arvalid || {m_axi_arprot, m_axi_araddr} != ar_hold)) viol++;
         if ((hs_aw && m_axi_awvalid) || (hs_w && m_axi_wvalid) || (hs_ar && m_axi_arvalid)) viol++;
         if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) viol++;
         hs_aw = m_axi_awvalid && m_axi_awready; pend_aw = m_axi_awvalid && !m_axi_awready;
         hs_w  = m_axi_wvalid && m_axi_wready;   pend_w  = m_axi_wvalid && !m_axi_wready;
         hs_ar = m_axi_arvalid && m_axi_arready; pend_ar = m_axi_arvalid && !m_axi_arready;
         aw_hold = {m_axi_awprot, m_axi_awaddr};
         w_hold  = {m_axi_wstrb, m_axi_wdata};
         ar_hold = {m_axi_arprot, m_axi_araddr};
         if (hs_aw) aw_q.push_back(aw_hold);
         if (hs_w)  w_q.push_back(w_hold);
         if (hs_ar) ar_q.push_back(ar_hold);
         if (int_wr_ack) begin wack_err.push_back(int_wr_err); wack_cyc.push_back(cyc); end
         else if (int_wr_err) viol++;
         if (int_rd_ack) begin rack_q.push_back({int_rd_err, int_rd_data}); rack_cyc.push_back(cyc); end
         else if (int_rd_err) viol++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_q();
      aw_q.delete(); w_q.delete(); ar_q.delete(); b_sent.delete(); r_sent.delete();
      wack_err.delete(); wack_cyc.delete(); rack_q.delete(); rack_cyc.delete();
   endtask

   task automatic issue(input bit w, input bit r, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s, output int c0);
      @(negedge m_axi_aclk);
      int_addr = a; int_wr_data = d; int_wr_strb = s; int_wr_en = w; int_rd_en = r;
      c0 = cyc;
      @(negedge m_axi_aclk);
      int_wr_en = 0; int_rd_en = 0;
   endtask

   task automatic wait_acks(input int nw, input int nr, input int budget);
      for (int i = 0; i < budget && (wack_err.size() < nw || rack_q.size() < nr); i++)
         @(negedge m_axi_aclk);
      repeat (3) @(negedge m_axi_aclk);
      chk("wr_ack_count", wack_err.size(), nw);
      chk("rd_ack_count", rack_q.size(), nr);
   endtask

   task automatic check_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [35:0] wv;
      chk("aw_count", aw_q.size(), 1);
      chk("w_count", w_q.size(), 1);
      if (aw_q.size() > 0) chk("aw_addr_prot", aw_q.pop_front(), {3'b000, a});
      if (w_q.size() > 0) begin
         wv = w_q.pop_front();
         chk("wdata", wv[31:0], d);
         chk("wstrb", wv[35:32], s);
      end
      if (b_sent.size() > 0 && wack_err.size() > 0)
         chk("wr_err", wack_err.pop_front(), exp_err(b_sent.pop_front()));
   endtask

   task automatic check_rd(input logic [9:0] a);
      logic [33:0] rs;
      chk("ar_count", ar_q.size(), 1);
      if (ar_q.size() > 0) chk("ar_addr_prot", ar_q.pop_front(), {3'b000, a});
      if (r_sent.size() > 0 && rack_q.size() > 0) begin
         rs = r_sent.pop_front();
         chk("rd_err_data", rack_q.pop_front(), {exp_err(rs[33:32]), rs[31:0]});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, gap;
      logic [9:0]  a, ra;
      logic [31:0] d;
      logic [3:0]  s;

      // reset values
      repeat (3) @(negedge m_axi_aclk);
      chk("reset_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                         int_wr_ack, int_wr_err, int_rd_ack, int_rd_err, int_wr_busy, int_rd_busy}, '0);
      chk("reset_rd_data", int_rd_data, '0);
      chk("reset_payload", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, '0);
      m_axi_aresetn = 1;
      repeat (2) @(negedge m_axi_aclk);
      chk("idle_after_reset", {int_wr_busy, int_rd_busy, m_axi_awvalid, m_axi_arvalid}, '0);

      // zero-wait write, 3-cycle latency
      issue(1, 0, 10'h104, 32'hDEADBEEF, 4'hF, c0);
      wait_acks(1, 0, 30);
      if (wack_cyc.size() > 0) chk("wr_latency", wack_cyc[0] - c0, 3);
      check_wr(10'h104, 32'hDEADBEEF, 4'hF);
      chk("wr_busy_idle", int_wr_busy, 0);
      clr_q();

      // read with 4 wait cycles on R, SLVERR
      r_dly = 4; rresp_cfg = RESP_SLVERR; rdata_cfg = 32'h12345678;
      issue(0, 1, 10'h020, '0, '0, c0);
      wait_acks(0, 1, 40);
      if (rack_cyc.size() > 0) chk("rd_latency", rack_cyc[0] - c0, 7);
      check_rd(10'h020);
      repeat (3) @(negedge m_axi_aclk);
      chk("rd_data_hold", int_rd_data, 32'h12345678);
      chk("rd_err_outside_ack", int_rd_err, 0);
      clr_q(); r_dly = 0; rresp_cfg = RESP_OKAY;

      // AW before W, then W before AW
      aw_dly = 0; w_dly = 5; bresp_cfg = RESP_DECERR;
      issue(1, 0, 10'h0F0, 32'hA5A5_0001, 4'h3, c0);
      wait_acks(1, 0, 40);
      check_wr(10'h0F0, 32'hA5A5_0001, 4'h3);
      clr_q();
      aw_dly = 5; w_dly = 0; bresp_cfg = RESP_EXOKAY;
      issue(1, 0, 10'h0F4, 32'h5A5A_0002, 4'hC, c0);
      wait_acks(1, 0, 40);
      check_wr(10'h0F4, 32'h5A5A_0002, 4'hC);
      clr_q(); aw_dly = 0; w_dly = 0;

      // simultaneous write+read, extra write while busy is dropped
      b_dly = 3; bresp_cfg = RESP_OKAY; rdata_cfg = 32'hCAFE_F00D;
      issue(1, 1, 10'h3FC, 32'h0BAD_F00D, 4'h9, c0);
      chk("wr_busy_active", int_wr_busy, 1);
      issue(1, 0, 10'h100, 32'h1111_2222, 4'hF, c0);
      wait_acks(1, 1, 50);
      check_wr(10'h3FC, 32'h0BAD_F00D, 4'h9);
      check_rd(10'h3FC);
      clr_q(); b_dly = 0;

      // reset in W_RESP / R_REQ
      b_dly = 20; ar_dly = 20;
      issue(1, 1, 10'h0A0, 32'h7777_8888, 4'hF, c0);
      for (int i = 0; i < 30 && !m_axi_bready; i++) @(negedge m_axi_aclk);
      chk("reached_w_resp", m_axi_bready, 1);
      chk("reached_r_req", m_axi_arvalid, 1);
      @(posedge m_axi_aclk); #2;
      m_axi_aresetn = 0;
      #1;
      chk("rst_axi_low", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, '0);
      chk("rst_busy_low", {int_wr_busy, int_rd_busy}, '0);
      repeat (2) @(negedge m_axi_aclk);
      m_axi_aresetn = 1;
      repeat (3) @(negedge m_axi_aclk);
      chk("no_ack_after_rst", wack_err.size() + rack_q.size(), 0);
      clr_q(); b_dly = 0; ar_dly = 0;
      issue(1, 0, 10'h044, 32'h0123_4567, 4'h5, c0);
      wait_acks(1, 0, 30);
      check_wr(10'h044, 32'h0123_4567, 4'h5);
      clr_q();

      // randomized traffic
      rand_dly = 1;
      for (int i = 0; i < 100; i++) begin
         a = 10'($urandom_range(0, 1023));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         gap = int'($urandom_range(0, 3));
         if (gap == 0) begin
            ra = a;
            issue(1, 1, a, d, s, c0);
         end else begin
            ra = 10'($urandom_range(0, 1023));
            issue(1, 0, a, d, s, c0);
            repeat (gap - 1) @(negedge m_axi_aclk);
            issue(0, 1, ra, '0, '0, c0);
         end
         wait_acks(1, 1, 200);
         check_wr(a, d, s);
         check_rd(ra);
         clr_q();
      end
      rand_dly = 0;

      chk("protocol_violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/int_axi4l.md
Name: int_axi4l

Overview:
- Internal-bus to AXI4-Lite master bridge. It is the initiator-side counterpart of axi4l_int.
- It accepts single-cycle write and read requests on the internal register bus (int_*) and issues them as AXI4-Lite master transactions (m_axi_*).
- It returns ack and err pulses to the requester.
- Used where internal logic (sequencers, CPU-less controllers) must drive AXI4-Lite slaves.

Parameters:
- ADDR_WIDTH, 10, byte address width on both sides.
- DATA_WIDTH, 32, data width. Only 32 is supported; strobe width is DATA_WIDTH/8.
- PROT, 3'b000, constant driven on m_axi_awprot and m_axi_arprot.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  asynchronous active-low reset
- int_addr  in  ADDR_WIDTH  request address, shared by write and read
- int_wr_data  in  DATA_WIDTH  write data
- int_wr_strb  in  DATA_WIDTH/8  write byte strobes
- int_wr_en  in  1  one-cycle write request pulse
- int_rd_en  in  1  one-cycle read request pulse
- int_wr_ack  out  1  one-cycle write completion pulse
- int_wr_err  out  1  valid with int_wr_ack; 1 = SLVERR or DECERR
- int_rd_ack  out  1  one-cycle read completion pulse
- int_rd_err  out  1  valid with int_rd_ack
- int_rd_data  out  DATA_WIDTH  read data, valid with int_rd_ack, held afterwards
- int_wr_busy  out  1  write engine not idle
- int_rd_busy  out  1  read engine not idle
- m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Clocking and reset: one clock, m_axi_aclk. Reset m_axi_aresetn is asynchronous, active-low.
- Reset values: every output is 0, including int_rd_data. Both FSMs are IDLE. All outputs are registered.

Engines:
- The write engine and the read engine are independent; each allows one outstanding transaction.
- int_wr_en and int_rd_en in the same cycle are legal. Both engines latch the same int_addr.

Write FSM, states W_IDLE, W_REQ, W_RESP, W_ACK:
- W_IDLE: on int_wr_en, latch addr, data and strb. Set awvalid=1 and wvalid=1. Go to W_REQ.
- W_REQ: awvalid drops on the AW handshake and wvalid drops on the W handshake; each drops independently. Payloads stay stable while the corresponding valid is high. When both handshakes are done (same or different cycles), go to W_RESP.
- W_RESP: bready=1. On bvalid: bready=0, capture err = bresp[1], go to W_ACK.
- W_ACK: int_wr_ack=1 for one cycle, int_wr_err=err. Go to W_IDLE.

Read FSM, states R_IDLE, R_REQ, R_RESP, R_ACK:
- R_IDLE: on int_rd_en, latch addr, set arvalid=1, go to R_REQ.
- R_REQ: on the AR handshake, go to R_RESP.
- R_RESP: rready=1. On rvalid: capture rdata and err = rresp[1], go to R_ACK.
- R_ACK: int_rd_ack=1 for one cycle. int_rd_data updates in the same cycle and holds until the next read ack. int_rd_err is valid only with the ack and is 0 otherwise.

Timing:
- Minimum latency with a zero-wait slave is 3 cycles, en→ack: request in cycle 0, valid in cycle 1, ready/response in cycle 2, ack in cycle 3.
- A new request is accepted in the cycle after the ack.

Busy and protocol rules:
- int_wr_busy is 1 whenever the write FSM is not in W_IDLE; int_rd_busy likewise for the read FSM.
- int_wr_en or int_rd_en while the matching busy=1 is a requester protocol violation. It is ignored: no latch, no ack, no AXI traffic.
- AXI rule: no valid is withdrawn before its handshake. EXOKAY is treated as OKAY (err=0).

Reset mid-operation:
- All valids and readies drop asynchronously and both FSMs return to IDLE.
- Pending requests are lost without an ack.

No timeout: a non-responding slave holds the engine busy indefinitely.

Decomposition:
- Shared package axi4l_pkg:
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - default prot constant;
  - write and read FSM state enums.
- No sub-module. The two engines are two always_ff blocks in one module.

Test Plan:
- Write addr 0x104, data 0xDEADBEEF, strb 0xF; slave always ready, bresp=00 → one AW and one W with those values, awprot=0, int_wr_ack in cycle 3, int_wr_err=0.
- Read addr 0x020; slave returns rdata=0x12345678 with rresp=10 after 4 wait cycles → int_rd_ack with int_rd_data=0x12345678 and int_rd_err=1; int_rd_data held afterwards.
- AW ready 5 cycles before W ready, and the reverse order → awvalid and wvalid each drop on their own handshake; bready only after both; exactly one ack.
- Simultaneous wr_en and rd_en at addr 0x3FC → both AXI transactions issued to 0x3FC; independent acks; an extra wr_en while busy → ignored, no second AW.
- Assert reset while in W_RESP and R_REQ → all m_axi valid/ready low immediately, no acks, busy=0; a subsequent write completes normally.
- Randomised: 100 writes and 100 reads, random slave delays (0–10) and random resp → every AXI transaction matches the internal request and resp[1] equals err, in order.
